// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// microsecond-to-tick conversion and the restart-counter width.
package reset_sequencer_pkg;

  localparam int RESTART_COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_PHY_RESET,
    ST_PHY_SETTLE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  function automatic int us_to_ticks(input int clock_hz, input int us);
    return (clock_hz / 1000000) * us;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (master) and the
// logic that supplies lock/link status and consumes the domain resets (slave).
interface reset_sequencer_if #(
  parameter int P_CHANNELS = 4
);
  import reset_sequencer_pkg::*;

  logic                           i_soft_reset;
  logic [P_CHANNELS-1:0]          i_lock;
  logic                           i_link_up;
  logic                           o_phy_reset_n;
  logic [P_CHANNELS-1:0]          o_reset;
  logic                           o_ready;
  logic [RESTART_COUNT_WIDTH-1:0] o_restart_count;

  modport master (
    input  i_soft_reset, i_lock, i_link_up,
    output o_phy_reset_n, o_reset, o_ready, o_restart_count
  );

  modport slave (
    output i_soft_reset, i_lock, i_link_up,
    input  o_phy_reset_n, o_reset, o_ready, o_restart_count
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for asynchronous status bits; each bit is
// synchronised independently, so multi-bit inputs must not be buses.
module bit_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] meta;

  // NOTE: flops use non-blocking assignments so both stages sample the
  // pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta   <= '0;
      o_data <= '0;
    end else begin
      meta   <= i_data;
      o_data <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / recovery reset sequencer: PHY reset, settle, then lock-gated
// per-channel releases. Define RESET_SEQUENCER_LINK_WATCHDOG_EN for the link watchdog.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int P_CLOCK_FREQUENCY_HZ = 125000000,
  parameter int P_CHANNELS           = 4,
  parameter int P_PHY_RESET_US       = 10000,
  parameter int P_PHY_SETTLE_US      = 20000,
  parameter int P_STAGE_TICKS        = 16,
  parameter int P_LINK_TIMEOUT_TICKS = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  reset_sequencer_if.master bus
);

  localparam int PHY_TICKS    = us_to_ticks(P_CLOCK_FREQUENCY_HZ, P_PHY_RESET_US);
  localparam int SETTLE_TICKS = us_to_ticks(P_CLOCK_FREQUENCY_HZ, P_PHY_SETTLE_US);
  localparam int CNT_W        = $clog2(max4(PHY_TICKS, SETTLE_TICKS, P_STAGE_TICKS,
                                            P_LINK_TIMEOUT_TICKS) + 1);
  localparam int STAGE_W      = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;

  localparam logic [CNT_W-1:0]   PHY_LAST    = CNT_W'(PHY_TICKS - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0]   STAGE_LAST  = CNT_W'(P_STAGE_TICKS - 1);
  localparam logic [STAGE_W-1:0] LAST_CH     = STAGE_W'(P_CHANNELS - 1);

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [STAGE_W-1:0]    stage;
  logic [P_CHANNELS-1:0] lock_sync;
  logic                  watchdog_fire;
  logic                  restart_req;
  logic                  loss_hit;
  logic [STAGE_W-1:0]    loss_idx;
  logic [P_CHANNELS-1:0] loss_mask;
  logic                  rel_fire;
  logic [STAGE_W-1:0]    rel_idx;

  bit_synchronizer #(.WIDTH(P_CHANNELS)) u_lock_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_data   (bus.i_lock),
    .o_data   (lock_sync)
  );

`ifdef RESET_SEQUENCER_LINK_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(P_LINK_TIMEOUT_TICKS - 1);

  logic             link_sync;
  logic [CNT_W-1:0] link_down_count;

  bit_synchronizer #(.WIDTH(1)) u_link_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_data   (bus.i_link_up),
    .o_data   (link_sync)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      link_down_count <= '0;
    end else if (state != ST_RUN || link_sync || watchdog_fire) begin
      link_down_count <= '0;
    end else begin
      link_down_count <= link_down_count + 1'b1;
    end
  end

  assign watchdog_fire = (state == ST_RUN) && !link_sync && (link_down_count == TIMEOUT_LAST);
`else
  logic unused_link_up;
  assign unused_link_up = bus.i_link_up;
  assign watchdog_fire  = 1'b0;
`endif

  assign restart_req = bus.i_soft_reset || watchdog_fire;

  // Lowest released channel whose lock has dropped; descending scan so index 0 wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    loss_hit  = 1'b0;
    loss_idx  = '0;
    loss_mask = '0;
    if (state == ST_RELEASE || state == ST_RUN) begin
      for (int k = P_CHANNELS - 1; k >= 0; k--) begin
        if (!bus.o_reset[k] && !lock_sync[k]) begin
          loss_hit = 1'b1;
          loss_idx = STAGE_W'(k);
        end
      end
    end
    for (int k = 0; k < P_CHANNELS; k++) begin
      loss_mask[k] = (k >= int'(loss_idx));
    end
  end

  // Channel 0 may release on the very edge the settle time expires.
  always_comb begin
    rel_fire = 1'b0;
    rel_idx  = stage;
    if (state == ST_PHY_SETTLE) begin
      rel_idx  = '0;
      rel_fire = (count == SETTLE_LAST) && lock_sync[0];
    end else if (state == ST_RELEASE) begin
      rel_fire = lock_sync[stage] && (stage == '0 || count >= STAGE_LAST);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state               <= ST_PHY_RESET;
      count               <= '0;
      stage               <= '0;
      bus.o_phy_reset_n   <= 1'b0;
      bus.o_reset         <= '1;
      bus.o_ready         <= 1'b0;
      bus.o_restart_count <= '0;
    end else if (restart_req) begin
      state             <= ST_PHY_RESET;
      count             <= '0;
      stage             <= '0;
      bus.o_phy_reset_n <= 1'b0;
      bus.o_reset       <= '1;
      bus.o_ready       <= 1'b0;
      if (bus.o_restart_count != '1) bus.o_restart_count <= bus.o_restart_count + 1'b1;
    end else if (loss_hit) begin
      state       <= ST_RELEASE;
      count       <= '0;
      stage       <= loss_idx;
      bus.o_reset <= bus.o_reset | loss_mask;
      bus.o_ready <= 1'b0;
      if (bus.o_restart_count != '1) bus.o_restart_count <= bus.o_restart_count + 1'b1;
    end else if (rel_fire) begin
      bus.o_reset[rel_idx] <= 1'b0;
      count                <= '0;
      if (rel_idx == LAST_CH) begin
        state       <= ST_RUN;
        bus.o_ready <= 1'b1;
      end else begin
        state <= ST_RELEASE;
        stage <= rel_idx + 1'b1;
      end
    end else begin
      case (state)
        ST_PHY_RESET: begin
          if (count == PHY_LAST) begin
            state             <= ST_PHY_SETTLE;
            count             <= '0;
            bus.o_phy_reset_n <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_PHY_SETTLE: begin
          if (count == SETTLE_LAST) begin
            state <= ST_RELEASE;
            count <= '0;
            stage <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (count != '1) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: an event-time model predicts every
// output change (cycle and value); a monitor pops and compares each change.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int CLK_HZ = 1000000;
  localparam int CH     = 3;
  localparam int PHY_US = 10;
  localparam int SET_US = 5;
  localparam int STAGE  = 3;
  localparam int WD     = 8;
  localparam int PHY_T  = (CLK_HZ / 1000000) * PHY_US;
  localparam int SET_T  = (CLK_HZ / 1000000) * SET_US;
  localparam int OW     = CH + 10;
  localparam logic [OW-1:0] RESET_VAL = {1'b0, {CH{1'b1}}, 1'b0, 8'd0};

  typedef struct {
    int            cyc;
    logic [OW-1:0] val;
  } event_t;

  logic i_clock = 1'b0;
  logic i_reset_n;
  int   edge_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  event_t sb[$];

  // Reference model state: the outputs the spec says should be present.
  logic          m_phy;
  logic [CH-1:0] m_rst;
  logic          m_ready;
  int            m_cnt;
  logic [OW-1:0] last_val;

  reset_sequencer_if #(.P_CHANNELS(CH)) bus ();

  reset_sequencer #(
    .P_CLOCK_FREQUENCY_HZ(CLK_HZ),
    .P_CHANNELS          (CH),
    .P_PHY_RESET_US      (PHY_US),
    .P_PHY_SETTLE_US     (SET_US),
    .P_STAGE_TICKS       (STAGE),
    .P_LINK_TIMEOUT_TICKS(WD)
  ) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [OW-1:0] dut_val();
    return {bus.o_phy_reset_n, bus.o_reset, bus.o_ready, bus.o_restart_count};
  endfunction

  function automatic logic [OW-1:0] model_val();
    return {m_phy, m_rst, m_ready, 8'(m_cnt)};
  endfunction

  task automatic expect_at(input int cyc);
    event_t e;
    if (model_val() != last_val) begin
      e.cyc = cyc;
      e.val = model_val();
      sb.push_back(e);
      last_val = e.val;
    end
  endtask

  task automatic bump_count();
    if (m_cnt < 255) m_cnt++;
  endtask

  // Channels first..CH-1 release in order, each no earlier than its lock is
  // visible and at least STAGE edges after the previous release.
  task automatic model_release(input int first, input int t_first, input int rdy[CH],
                               output int t_done);
    int t;
    t = t_first;
    for (int k = first; k < CH; k++) begin
      if (k > first) t = t + STAGE;
      if (rdy[k] > t) t = rdy[k];
      m_rst[k] = 1'b0;
      if (k == CH - 1) m_ready = 1'b1;
      expect_at(t);
    end
    t_done = t;
  endtask

  task automatic model_restart(input int t, input int rdy[CH], output int t_done);
    m_phy = 1'b0; m_rst = '1; m_ready = 1'b0;
    bump_count();
    expect_at(t);
    m_phy = 1'b1;
    expect_at(t + PHY_T);
    model_release(0, t + PHY_T + SET_T, rdy, t_done);
  endtask

  task automatic model_loss(input int t, input int k, input int rdy[CH], output int t_done);
    for (int j = k; j < CH; j++) m_rst[j] = 1'b1;
    m_ready = 1'b0;
    bump_count();
    expect_at(t);
    model_release(k, (k == 0) ? t + 1 : t + STAGE, rdy, t_done);
  endtask

  task automatic wait_edge(input int c);
    while (edge_cnt < c) @(negedge i_clock);
  endtask

  task automatic do_reset(input logic [CH-1:0] locks, output int t0);
    @(posedge i_clock);
    #2;
    i_reset_n   = 1'b0;
    bus.i_lock  = locks;
    @(negedge i_clock);
    check("reset_state", 32'(dut_val()), 32'(RESET_VAL));
    m_phy = 1'b0; m_rst = '1; m_ready = 1'b0; m_cnt = 0;
    last_val = model_val();
    repeat (2) @(negedge i_clock);
    @(posedge i_clock);
    #2;
    i_reset_n = 1'b1;
    t0 = edge_cnt;
  endtask

  initial begin : monitor
    logic [OW-1:0] prev, cur;
    event_t e;
    prev = RESET_VAL;
    forever begin
      @(negedge i_clock);
      cur = dut_val();
      if (!i_reset_n) begin
        prev = RESET_VAL;
      end else begin
        while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
          e = sb.pop_front();
          check("missed_event_cycle", 32'(edge_cnt), 32'(e.cyc));
        end
        if (cur !== prev) begin
          if (sb.size() == 0) begin
            check("unexpected_change", 32'(cur), 32'(prev));
          end else begin
            e = sb.pop_front();
            check("event_cycle", 32'(edge_cnt), 32'(e.cyc));
            check("event_value", 32'(cur), 32'(e.val));
          end
          prev = cur;
        end
      end
    end
  end

  initial begin : stim
    int t0, t_done, L, s0;
    int rdy[CH];
    i_reset_n        = 1'b0;
    bus.i_soft_reset = 1'b0;
    bus.i_lock       = '1;
    bus.i_link_up    = 1'b1;

    // Power-on with all locks already high.
    do_reset('1, t0);
    rdy = '{default: 0};
    m_phy = 1'b1;
    expect_at(t0 + PHY_T);
    model_release(0, t0 + PHY_T + SET_T, rdy, t_done);
    wait_edge(t_done + 6);

    // Channel 1 lock arrives late, at a random cycle.
    do_reset(CH'(~(1 << 1)), t0);
    L = 25 + int'($urandom_range(0, 20));
    rdy = '{default: 0};
    rdy[1] = t0 + L + 3;
    m_phy = 1'b1;
    expect_at(t0 + PHY_T);
    model_release(0, t0 + PHY_T + SET_T, rdy, t_done);
    wait_edge(t0 + L);
    bus.i_lock[1] = 1'b1;
    wait_edge(t_done + 6);

    // Random lock-loss patterns in ST_RUN; the lowest dropped index restarts.
    for (int n = 0; n < 6; n++) begin
      int mask, k, last_m;
      int m_at[CH];
      mask   = int'($urandom_range(1, (1 << CH) - 1));
      k      = -1;
      L      = edge_cnt + 2;
      last_m = L;
      for (int j = 0; j < CH; j++) begin
        rdy[j]  = 0;
        m_at[j] = 0;
        if (mask[j]) begin
          m_at[j] = L + 1 + int'($urandom_range(0, 8));
          rdy[j]  = m_at[j] + 3;
          if (k < 0) k = j;
          if (m_at[j] > last_m) last_m = m_at[j];
        end
      end
      model_loss(L + 3, k, rdy, t_done);
      for (int c = L; c <= last_m; c++) begin
        wait_edge(c);
        for (int j = 0; j < CH; j++) if (mask[j]) bus.i_lock[j] = (c >= m_at[j]);
      end
      wait_edge(t_done + 4);
    end

    // Soft reset on the same edge that a channel 0 lock loss is seen.
    s0 = edge_cnt + 5;
    L  = s0 + 4 + int'($urandom_range(0, 20));
    rdy = '{default: 0};
    rdy[0] = L + 3;
    model_restart(s0, rdy, t_done);
    wait_edge(s0 - 3);
    bus.i_lock[0] = 1'b0;
    wait_edge(s0 - 1);
    bus.i_soft_reset = 1'b1;
    wait_edge(s0);
    bus.i_soft_reset = 1'b0;
    wait_edge(L);
    bus.i_lock[0] = 1'b1;
    wait_edge(t_done + 6);

    // 300 soft resets: the restart count must saturate at 255.
    s0 = edge_cnt + 2;
    m_phy = 1'b0; m_rst = '1; m_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bump_count();
      expect_at(s0 + 2 * i);
    end
    rdy = '{default: 0};
    m_phy = 1'b1;
    expect_at(s0 + 598 + PHY_T);
    model_release(0, s0 + 598 + PHY_T + SET_T, rdy, t_done);
    for (int i = 0; i < 300; i++) begin
      wait_edge(s0 + 2 * i - 1);
      bus.i_soft_reset = 1'b1;
      wait_edge(s0 + 2 * i);
      bus.i_soft_reset = 1'b0;
    end
    wait_edge(t_done + 4);
    check("restart_count_saturated", 32'(bus.o_restart_count), 32'd255);

`ifdef RESET_SEQUENCER_LINK_WATCHDOG_EN
    // Link down for one cycle short of the timeout: no restart.
    L = edge_cnt + 2;
    wait_edge(L);
    bus.i_link_up = 1'b0;
    wait_edge(L + WD - 1);
    bus.i_link_up = 1'b1;
    wait_edge(L + 20);
    // Link down past the timeout: full restart.
    L = edge_cnt + 2;
    rdy = '{default: 0};
    model_restart(L + 2 + WD, rdy, t_done);
    wait_edge(L);
    bus.i_link_up = 1'b0;
    wait_edge(L + 2 + WD);
    bus.i_link_up = 1'b1;
    wait_edge(t_done + 6);
`else
    // Without the watchdog the link status has no effect.
    L = edge_cnt + 2;
    wait_edge(L);
    bus.i_link_up = 1'b0;
    wait_edge(L + 3 * WD);
    bus.i_link_up = 1'b1;
    wait_edge(L + 3 * WD + 6);
`endif

    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and recovery reset sequencer for the Ethernet designs. It holds the external PHY in reset, waits for it to settle, then releases P_CHANNELS synchronous active-high domain resets one at a time. Each release is gated by that channel's lock input (for example transceiver PLL, PCS or MAC core). It replaces the free-running reset counter in the SGMII top levels. It adds per-channel lock gating, partial re-sequencing on lock loss, a software restart and an optional link watchdog.

## Interface
- P_CLOCK_FREQUENCY_HZ, 125000000, i_clock frequency.
- P_CHANNELS, 4, number of released domains (1..16).
- P_PHY_RESET_US, 10000, o_phy_reset_n low time.
- P_PHY_SETTLE_US, 20000, wait after PHY release before channel 0.
- P_STAGE_TICKS, 16, minimum cycles between consecutive channel releases (≥1).
- P_LINK_TIMEOUT_TICKS, 1000000, consecutive link-down cycles that trigger a re-sequence (watchdog only).
- i_clock  in  1  single clock; all logic is on its rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_soft_reset  in  1  synchronous one-cycle restart request.
- i_lock  in  P_CHANNELS  asynchronous per-channel ready/lock; synchronised internally.
- i_link_up  in  1  asynchronous PHY link status; synchronised internally.
- o_phy_reset_n  out  1  PHY reset, active low.
- o_reset  out  P_CHANNELS  synchronous active-high domain resets.
- o_ready  out  1  all channels released.
- o_restart_count  out  8  saturating count of re-sequences since i_reset_n.

## Operation
- Tick conversion: ticks = (P_CLOCK_FREQUENCY_HZ/1000000)*US.
- Counter width: $clog2(max(phy ticks, settle ticks, P_STAGE_TICKS, P_LINK_TIMEOUT_TICKS)+1).
- FSM states:
  - ST_PHY_RESET: o_phy_reset_n=0, all o_reset=1. Go to ST_PHY_SETTLE after PHY_RESET ticks.
  - ST_PHY_SETTLE: o_phy_reset_n=1. Go to ST_RELEASE, stage=0, after SETTLE ticks.
  - ST_RELEASE: release channel `stage` when synced i_lock[stage]=1 and the stage counter ≥ P_STAGE_TICKS−1. Channel 0 has no stage-counter requirement. On release the counter clears and stage increments. After releasing channel P_CHANNELS−1, go to ST_RUN.
  - ST_RUN: o_ready=1.
- Lock loss: in ST_RELEASE or ST_RUN, synced i_lock[k]=0 for an already-released channel k. Response:
  - assert o_reset[k..P_CHANNELS−1] and drop o_ready;
  - go to ST_RELEASE with stage=k and the counter cleared;
  - increment o_restart_count;
  - lower channels stay released and the PHY is untouched.
  - If several channels lose lock, the lowest index wins.
- i_soft_reset=1 in any state: full restart into ST_PHY_RESET with the counter cleared. All outputs take reset values except o_restart_count, which increments.
- Simultaneous soft reset and lock loss: soft reset wins and the count increments once.
- o_restart_count saturates at 255.
- i_reset_n low at any time: asynchronous return to reset values and ST_PHY_RESET.

## Timing
- Reset values: o_phy_reset_n=0, o_reset=all 1, o_ready=0, o_restart_count=0.
- All outputs are registered.
- i_lock and i_link_up have 2 cycles of synchroniser latency.
- o_phy_reset_n is low for exactly PHY_RESET ticks, counted from the first rising edge after i_reset_n deasserts.
- o_reset[0] falls SETTLE ticks after o_phy_reset_n rises, provided the synced lock is already high.
- Consecutive o_reset falls are ≥P_STAGE_TICKS cycles apart.
- o_ready rises in the same cycle as o_reset[P_CHANNELS−1] falls.
- Lock loss response: o_reset asserts 1 cycle after the synced lock drops.
- Soft reset response: o_phy_reset_n falls on the cycle after i_soft_reset is sampled.

## Configuration
- RESET_SEQUENCER_LINK_WATCHDOG_EN defined:
  - in ST_RUN, count consecutive cycles with synced i_link_up=0;
  - any cycle with link up clears the count;
  - reaching P_LINK_TIMEOUT_TICKS triggers a full restart, identical to soft reset.
- Undefined: i_link_up is ignored and the watchdog counter is not instantiated.

## Structure
- reset_sequencer_pkg holds the state enum, the us-to-ticks function and the restart-counter width constant.
- One sub-module, bit_synchronizer: a 2-flop synchroniser with WIDTH parameter, instantiated for i_lock and for i_link_up.

## Test plan
All scenarios use P_CLOCK_FREQUENCY_HZ=1000000, P_CHANNELS=3, P_PHY_RESET_US=10, P_PHY_SETTLE_US=5, P_STAGE_TICKS=3, P_LINK_TIMEOUT_TICKS=8.
- Locks high, release reset:
  - o_phy_reset_n low 10 cycles;
  - o_reset[0] falls at cycle 15, [1] at 18, [2] at 21;
  - o_ready=1 at 21.
- i_lock[1] held low until cycle 40: o_reset[1] falls 2–3 cycles after lock rises, then o_reset[2] falls 3 cycles after o_reset[1].
- Drop i_lock[1] in ST_RUN:
  - o_reset[1:2]=1 and o_ready=0 3 cycles later;
  - o_reset[0] and o_phy_reset_n unchanged;
  - o_restart_count=1.
- i_soft_reset together with i_lock[0] drop: full PHY restart and o_restart_count increments by exactly 1.
- 300 soft resets: o_restart_count=255.
- Watchdog macro defined, i_link_up low 7 cycles then high: no restart. Low 10 cycles: o_phy_reset_n falls.
